// File: rtl/match_lock_detector.sv
// match_lock_detector
// Registered consumer of a WIDTH-bit equality compare. Each valid sample
// registers (a == b) and advances a small FSM that counts consecutive
// matches. The FSM declares lock after LOCK_COUNT consecutive matches. It
// drops lock after MISS_TOL consecutive mismatches seen while locked.
//
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - asynchronous active-low reset
//   a, b         - WIDTH-bit operands
//   valid        - operands valid this cycle; no sample is taken when low
//   clear        - synchronous soft clear back to IDLE; wins over valid
//   eq_q         - registered (a == b) from the last valid sample
//   run_cnt      - consecutive-match count; saturates while locked
//   locked       - high while the FSM is in LOCKED
//   lock_pulse   - one-cycle pulse on entry to LOCKED
//   unlock_pulse - one-cycle pulse on a mismatch-driven exit from LOCKED
module match_lock_detector #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_TOL   = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             valid,
  input  logic             clear,
  output logic             eq_q,
  output logic [CNT_W-1:0] run_cnt,
  output logic             locked,
  output logic             lock_pulse,
  output logic             unlock_pulse
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] MISS_C  = CNT_W'(MISS_TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]       state_r,    state_nxt_s;
  logic             eq_r,       eq_nxt_s;
  logic [CNT_W-1:0] run_r,      run_nxt_s;
  logic [CNT_W-1:0] miss_r,     miss_nxt_s;
  logic             locked_r;
  logic             lock_p_r,   lock_p_nxt_s;
  logic             unlock_p_r, unlock_p_nxt_s;
  logic             match_s;
  logic [CNT_W-1:0] run_inc_s;
  logic [CNT_W-1:0] miss_inc_s;

  assign match_s    = (a == b);
  assign run_inc_s  = run_r + CNT_ONE;
  assign miss_inc_s = miss_r + CNT_ONE;

  // Next-state, counter and pulse computation; pulses default low every cycle.
  always_comb begin
    state_nxt_s    = state_r;
    eq_nxt_s       = eq_r;
    run_nxt_s      = run_r;
    miss_nxt_s     = miss_r;
    lock_p_nxt_s   = 1'b0;
    unlock_p_nxt_s = 1'b0;
    if (clear) begin
      // Soft clear never raises unlock_pulse, even from LOCKED.
      state_nxt_s = IDLE;
      eq_nxt_s    = 1'b0;
      run_nxt_s   = CNT_ZERO;
      miss_nxt_s  = CNT_ZERO;
    end else if (valid) begin
      eq_nxt_s = match_s;
      case (state_r)
        IDLE: begin
          miss_nxt_s = CNT_ZERO;
          if (match_s) begin
            run_nxt_s = CNT_ONE;
            if (LOCK_C == CNT_ONE) begin
              state_nxt_s  = LOCKED;
              lock_p_nxt_s = 1'b1;
            end else begin
              state_nxt_s = TRACK;
            end
          end else begin
            run_nxt_s   = CNT_ZERO;
            state_nxt_s = IDLE;
          end
        end
        TRACK: begin
          // run_cnt stays below LOCK_COUNT here, so the increment cannot wrap.
          miss_nxt_s = CNT_ZERO;
          if (match_s) begin
            run_nxt_s = run_inc_s;
            if (run_inc_s == LOCK_C) begin
              state_nxt_s  = LOCKED;
              lock_p_nxt_s = 1'b1;
            end else begin
              state_nxt_s = TRACK;
            end
          end else begin
            run_nxt_s   = CNT_ZERO;
            state_nxt_s = IDLE;
          end
        end
        LOCKED: begin
          if (match_s) begin
            miss_nxt_s = CNT_ZERO;
            if (run_r == CNT_MAX) begin
              run_nxt_s = CNT_MAX;
            end else begin
              run_nxt_s = run_inc_s;
            end
          end else if (miss_inc_s == MISS_C) begin
            state_nxt_s    = IDLE;
            run_nxt_s      = CNT_ZERO;
            miss_nxt_s     = CNT_ZERO;
            unlock_p_nxt_s = 1'b1;
          end else begin
            // A tolerated miss holds run_cnt and only advances the miss count.
            miss_nxt_s = miss_inc_s;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          run_nxt_s   = CNT_ZERO;
          miss_nxt_s  = CNT_ZERO;
        end
      endcase
    end else begin
      // No sample: everything holds, and the pulses fall back to 0.
      state_nxt_s = state_r;
      run_nxt_s   = run_r;
      miss_nxt_s  = miss_r;
    end
  end

  // State and output registers; locked is decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      eq_r       <= 1'b0;
      run_r      <= CNT_ZERO;
      miss_r     <= CNT_ZERO;
      locked_r   <= 1'b0;
      lock_p_r   <= 1'b0;
      unlock_p_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      eq_r       <= eq_nxt_s;
      run_r      <= run_nxt_s;
      miss_r     <= miss_nxt_s;
      locked_r   <= (state_nxt_s == LOCKED);
      lock_p_r   <= lock_p_nxt_s;
      unlock_p_r <= unlock_p_nxt_s;
    end
  end

  assign eq_q         = eq_r;
  assign run_cnt      = run_r;
  assign locked       = locked_r;
  assign lock_pulse   = lock_p_r;
  assign unlock_pulse = unlock_p_r;

endmodule
